// File: rtl/commit_csr_unit_pkg.sv
// Shared types, CSR addresses and helpers for the commit/CSR unit.
package commit_csr_unit_pkg;

    typedef logic [4:0]  reg_id_t;
    typedef logic [11:0] csr_addr_t;
    typedef logic [31:0] data_t;
    typedef logic [31:0] vaddr_t;
    typedef logic [4:0]  excpt_cause_t;

    localparam csr_addr_t CSR_MSTATUS   = 12'h300;
    localparam csr_addr_t CSR_MTVEC     = 12'h305;
    localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
    localparam csr_addr_t CSR_MEPC      = 12'h341;
    localparam csr_addr_t CSR_MCAUSE    = 12'h342;
    localparam csr_addr_t CSR_MTVAL     = 12'h343;
    localparam csr_addr_t CSR_SATP      = 12'h180;
    localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
    localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
    localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
    localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
    localparam csr_addr_t CSR_MHARTID   = 12'hF14;

    typedef struct packed {
        logic [1:0] mpp;
        logic       mpie;
        logic       mie;
    } mstatus_t;

    typedef enum logic {
        RD_IDLE,
        RD_FIRE
    } redirect_state_e;

    function automatic data_t mstatus_pack(mstatus_t s);
        return {19'b0, s.mpp, 3'b0, s.mpie, 3'b0, s.mie, 3'b0};
    endfunction

endpackage

// File: rtl/commit_csr_unit_if.sv
// ROB head commit/exception bundle into the commit unit.
interface commit_csr_unit_if;
    import commit_csr_unit_pkg::*;

    logic         commit_valid;
    logic         commit_is_wb;
    logic         commit_is_csr_wb;
    logic         commit_is_mret;
    reg_id_t      commit_reg_id;
    csr_addr_t    commit_csr_addr;
    data_t        commit_data;
    data_t        commit_csr_data;
    vaddr_t       commit_pc;
    logic         flush;
    logic         excp_we;
    excpt_cause_t excp_cause;
    data_t        excp_pc;
    data_t        excp_tval;

    modport master (
        output commit_valid, commit_is_wb, commit_is_csr_wb,
        output commit_is_mret, commit_reg_id, commit_csr_addr,
        output commit_data, commit_csr_data, commit_pc, flush,
        output excp_we, excp_cause, excp_pc, excp_tval
    );

    modport slave (
        input commit_valid, commit_is_wb, commit_is_csr_wb,
        input commit_is_mret, commit_reg_id, commit_csr_addr,
        input commit_data, commit_csr_data, commit_pc, flush,
        input excp_we, excp_cause, excp_pc, excp_tval
    );

endinterface

// File: rtl/commit_csr_unit_counters.sv
// mcycle / minstret 64-bit counters; a CSR write to the low word wins over counting.
module commit_csr_unit_counters
    import commit_csr_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        retire_i,
    input  logic        we_i,
    input  csr_addr_t   waddr_i,
    input  data_t       wdata_i,
    output logic [63:0] mcycle_o,
    output logic [63:0] minstret_o
);

    logic [63:0] mcycle_d, mcycle_q;
    logic [63:0] minstret_d, minstret_q;

    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'b0, retire_i};
        if (we_i && waddr_i == CSR_MCYCLE) begin
            mcycle_d = {mcycle_q[63:32], wdata_i};
        end
        if (we_i && waddr_i == CSR_MINSTRET) begin
            minstret_d = {minstret_q[63:32], wdata_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mcycle_o   = mcycle_q;
    assign minstret_o = minstret_q;

endmodule

// File: rtl/commit_csr_unit.sv
// In-order commit: RF writeback, M-mode CSRs, trap/mret and front-end redirect.
module commit_csr_unit
    import commit_csr_unit_pkg::*;
#(
    parameter data_t MTVEC_RESET = 32'h0000_0100,
    parameter data_t HART_ID     = 32'h0
)(
    input  logic               clk_i,
    input  logic               rst_i,
    commit_csr_unit_if.slave   cmt,
    input  csr_addr_t          csr_raddr_i,
    output logic               rf_we_o,
    output reg_id_t            rf_waddr_o,
    output data_t              rf_wdata_o,
    output data_t              csr_rdata_o,
    output logic               redirect_valid_o,
    output vaddr_t             redirect_pc_o,
    output data_t              satp_o,
    output logic               mie_o
);

    logic trap, retire, csr_we, do_mret, satp_wr;

    assign trap    = cmt.excp_we;
    assign retire  = cmt.commit_valid & ~cmt.excp_we;
    assign csr_we  = retire & cmt.commit_is_csr_wb;
    assign do_mret = retire & cmt.commit_is_mret;
    assign satp_wr = csr_we & (cmt.commit_csr_addr == CSR_SATP);

    assign rf_we_o    = retire & cmt.commit_is_wb &
                        (cmt.commit_reg_id != '0);
    assign rf_waddr_o = cmt.commit_reg_id;
    assign rf_wdata_o = cmt.commit_data;

    mstatus_t mstatus_d, mstatus_q;
    data_t    mtvec_d, mtvec_q;
    data_t    mscratch_d, mscratch_q;
    data_t    mepc_d, mepc_q;
    data_t    mcause_d, mcause_q;
    data_t    mtval_d, mtval_q;
    data_t    satp_d, satp_q;

    logic [63:0] mcycle, minstret;

    commit_csr_unit_counters u_counters (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .retire_i   (retire),
        .we_i       (csr_we),
        .waddr_i    (cmt.commit_csr_addr),
        .wdata_i    (cmt.commit_csr_data),
        .mcycle_o   (mcycle),
        .minstret_o (minstret)
    );

    always_comb begin
        mstatus_d  = mstatus_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        satp_d     = satp_q;
        if (trap) begin
            mepc_d         = cmt.excp_pc;
            mcause_d       = {{($bits(data_t) - $bits(excpt_cause_t)){1'b0}},
                              cmt.excp_cause};
            mtval_d        = cmt.excp_tval;
            mstatus_d.mpie = mstatus_q.mie;
            mstatus_d.mie  = 1'b0;
            mstatus_d.mpp  = 2'b11;
        end else if (do_mret) begin
            mstatus_d.mie  = mstatus_q.mpie;
            mstatus_d.mpie = 1'b1;
            mstatus_d.mpp  = 2'b11;
        end
        if (csr_we) begin
            case (cmt.commit_csr_addr)
                CSR_MSTATUS: begin
                    mstatus_d.mpp  = cmt.commit_csr_data[12:11];
                    mstatus_d.mpie = cmt.commit_csr_data[7];
                    mstatus_d.mie  = cmt.commit_csr_data[3];
                end
                CSR_MTVEC:    mtvec_d    = {cmt.commit_csr_data[31:2], 2'b00};
                CSR_MSCRATCH: mscratch_d = cmt.commit_csr_data;
                CSR_MEPC:     mepc_d     = {cmt.commit_csr_data[31:1], 1'b0};
                CSR_MCAUSE:   mcause_d   = cmt.commit_csr_data;
                CSR_MTVAL:    mtval_d    = cmt.commit_csr_data;
                CSR_SATP:     satp_d     = cmt.commit_csr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mstatus_q  <= '{mpp: 2'b11, mpie: 1'b0, mie: 1'b0};
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            satp_q     <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            satp_q     <= satp_d;
        end
    end

    // Target is captured from pre-update CSR state at the flush edge.
    vaddr_t redirect_tgt;

    always_comb begin
        redirect_tgt = cmt.commit_pc + 32'd4;
        if (trap) begin
            redirect_tgt = {mtvec_q[31:2], 2'b00};
        end else if (do_mret) begin
            redirect_tgt = mepc_q;
        end else if (satp_wr) begin
            redirect_tgt = cmt.commit_pc + 32'd4;
        end
    end

    redirect_state_e state_q;
    vaddr_t          redirect_pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= RD_IDLE;
            redirect_pc_q <= '0;
        end else begin
            case (state_q)
                RD_IDLE, RD_FIRE: begin
                    if (cmt.flush) begin
                        state_q       <= RD_FIRE;
                        redirect_pc_q <= redirect_tgt;
                    end else begin
                        state_q <= RD_IDLE;
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    assign redirect_valid_o = (state_q == RD_FIRE);
    assign redirect_pc_o    = redirect_pc_q;
    assign satp_o           = satp_q;
    assign mie_o            = mstatus_q.mie;

    always_comb begin
        csr_rdata_o = '0;
        case (csr_raddr_i)
            CSR_MSTATUS:   csr_rdata_o = mstatus_pack(mstatus_q);
            CSR_MTVEC:     csr_rdata_o = mtvec_q;
            CSR_MSCRATCH:  csr_rdata_o = mscratch_q;
            CSR_MEPC:      csr_rdata_o = mepc_q;
            CSR_MCAUSE:    csr_rdata_o = mcause_q;
            CSR_MTVAL:     csr_rdata_o = mtval_q;
            CSR_SATP:      csr_rdata_o = satp_q;
            CSR_MCYCLE:    csr_rdata_o = mcycle[31:0];
            CSR_MCYCLEH:   csr_rdata_o = mcycle[63:32];
            CSR_MINSTRET:  csr_rdata_o = minstret[31:0];
            CSR_MINSTRETH: csr_rdata_o = minstret[63:32];
            CSR_MHARTID:   csr_rdata_o = HART_ID;
            default:       csr_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_commit_csr_unit.sv
// Directed bench for commit_csr_unit: vector table plus multi-cycle sequences.
module tb_commit_csr_unit;
    import commit_csr_unit_pkg::*;

    logic      clk_i = 1'b0;
    logic      rst_i;
    csr_addr_t csr_raddr_i;
    logic      rf_we_o;
    reg_id_t   rf_waddr_o;
    data_t     rf_wdata_o;
    data_t     csr_rdata_o;
    logic      redirect_valid_o;
    vaddr_t    redirect_pc_o;
    data_t     satp_o;
    logic      mie_o;

    int total = 0;
    int bad   = 0;

    commit_csr_unit_if cif ();

    commit_csr_unit #(
        .MTVEC_RESET (32'h0000_0100),
        .HART_ID     (32'h0)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cmt              (cif),
        .csr_raddr_i      (csr_raddr_i),
        .rf_we_o          (rf_we_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .csr_rdata_o      (csr_rdata_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .satp_o           (satp_o),
        .mie_o            (mie_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic      v;
        logic      wb;
        logic      ex;
        reg_id_t   rid;
        data_t     data;
        csr_addr_t raddr;
        logic      exp_we;
        data_t     exp_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear();
        cif.commit_valid     = 1'b0;
        cif.commit_is_wb     = 1'b0;
        cif.commit_is_csr_wb = 1'b0;
        cif.commit_is_mret   = 1'b0;
        cif.commit_reg_id    = '0;
        cif.commit_csr_addr  = '0;
        cif.commit_data      = '0;
        cif.commit_csr_data  = '0;
        cif.commit_pc        = '0;
        cif.flush            = 1'b0;
        cif.excp_we          = 1'b0;
        cif.excp_cause       = '0;
        cif.excp_pc          = '0;
        cif.excp_tval        = '0;
        csr_raddr_i          = '0;
    endtask

    task automatic rd(input string name, input csr_addr_t a,
                      input data_t exp);
        csr_raddr_i = a;
        #1;
        chk(name, csr_rdata_o, exp);
    endtask

    task automatic csr_wr(input csr_addr_t a, input data_t d);
        cif.commit_valid     = 1'b1;
        cif.commit_is_csr_wb = 1'b1;
        cif.commit_csr_addr  = a;
        cif.commit_csr_data  = d;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd5,  32'hDEAD_BEEF, CSR_MTVEC,     1'b1, 32'h100};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_1234, CSR_MSTATUS,   1'b0, 32'h1800};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 5'd7,  32'h0000_0055, CSR_MHARTID,   1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 5'd7,  32'h0000_0055, CSR_MSCRATCH,  1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd7,  32'h0000_0055, 12'h123,       1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 5'd31, 32'h0000_A5A5, CSR_MINSTRET,  1'b1, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 5'd1,  32'h0000_0001, CSR_MINSTRETH, 1'b1, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         CSR_MEPC,      1'b0, 32'h0};

        do_reset();
        chk("rst_redir_valid", redirect_valid_o, 0);
        chk("rst_redir_pc", redirect_pc_o, 0);
        chk("rst_satp", satp_o, 0);
        chk("rst_mie", mie_o, 0);
        chk("rst_rf_we", rf_we_o, 0);

        // Vectors are cleared before each edge, so nothing commits.
        for (int i = 0; i < 8; i++) begin
            cif.commit_valid  = vecs[i].v;
            cif.commit_is_wb  = vecs[i].wb;
            cif.excp_we       = vecs[i].ex;
            cif.commit_reg_id = vecs[i].rid;
            cif.commit_data   = vecs[i].data;
            csr_raddr_i       = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d_we", i), rf_we_o, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                chk($sformatf("vec%0d_wdata", i), rf_wdata_o, vecs[i].data);
                chk($sformatf("vec%0d_waddr", i), rf_waddr_o, vecs[i].rid);
            end
            chk($sformatf("vec%0d_rdata", i), csr_rdata_o, vecs[i].exp_rd);
            clear();
            tick();
        end

        cif.commit_valid  = 1'b1;
        cif.commit_is_wb  = 1'b1;
        cif.commit_reg_id = 5'd5;
        cif.commit_data   = 32'hDEAD_BEEF;
        #1;
        chk("wb_x5_we", rf_we_o, 1);
        tick();
        cif.commit_reg_id = 5'd0;
        #1;
        chk("wb_x0_we", rf_we_o, 0);
        tick();
        clear();
        rd("minstret_2", CSR_MINSTRET, 32'd2);

        tick();
        cif.commit_valid  = 1'b1;
        cif.commit_is_wb  = 1'b1;
        cif.commit_reg_id = 5'd3;
        cif.excp_we       = 1'b1;
        cif.excp_cause    = 5'd5;
        cif.excp_pc       = 32'h80;
        cif.excp_tval     = 32'h44;
        cif.flush         = 1'b1;
        #1;
        chk("trap_rf_we", rf_we_o, 0);
        tick();
        clear();
        chk("trap_redir_valid", redirect_valid_o, 1);
        chk("trap_redir_pc", redirect_pc_o, 32'h100);
        chk("trap_mie", mie_o, 0);
        tick();
        chk("trap_redir_once", redirect_valid_o, 0);
        rd("trap_mepc", CSR_MEPC, 32'h80);
        rd("trap_mtval", CSR_MTVAL, 32'h44);
        rd("trap_mcause", CSR_MCAUSE, 32'h5);
        rd("trap_minstret", CSR_MINSTRET, 32'd2);
        rd("trap_mstatus", CSR_MSTATUS, 32'h1800);

        tick();
        csr_wr(CSR_MSTATUS, 32'h8);
        tick();
        clear();
        chk("mstatus_mie_set", mie_o, 1);
        cif.excp_we = 1'b1;
        cif.excp_pc = 32'h120;
        cif.flush   = 1'b1;
        tick();
        clear();
        chk("trap2_mie", mie_o, 0);
        chk("trap2_redir_pc", redirect_pc_o, 32'h100);
        rd("trap2_mstatus", CSR_MSTATUS, 32'h1880);
        cif.commit_valid   = 1'b1;
        cif.commit_is_mret = 1'b1;
        cif.flush          = 1'b1;
        tick();
        clear();
        chk("mret_redir_valid", redirect_valid_o, 1);
        chk("mret_redir_pc", redirect_pc_o, 32'h120);
        chk("mret_mie", mie_o, 1);
        rd("mret_mstatus", CSR_MSTATUS, 32'h1888);

        tick();
        csr_wr(CSR_SATP, 32'h8000_0001);
        cif.commit_pc = 32'h200;
        cif.flush     = 1'b1;
        #1;
        chk("satp_not_fwd", satp_o, 0);
        tick();
        clear();
        cif.commit_pc = 32'h300;
        cif.flush     = 1'b1;
        chk("satp_out", satp_o, 32'h8000_0001);
        chk("satp_redir_valid", redirect_valid_o, 1);
        chk("satp_redir_pc", redirect_pc_o, 32'h204);
        tick();
        clear();
        chk("flush2_redir_valid", redirect_valid_o, 1);
        chk("flush2_redir_pc", redirect_pc_o, 32'h304);
        tick();
        chk("flush2_idle", redirect_valid_o, 0);

        csr_wr(CSR_MTVEC, 32'h203);
        tick();
        clear();
        rd("mtvec_wr", CSR_MTVEC, 32'h200);
        tick();
        cif.commit_pc = 32'h10;
        cif.flush     = 1'b1;
        tick();
        clear();
        chk("prerst_redir_valid", redirect_valid_o, 1);
        chk("prerst_redir_pc", redirect_pc_o, 32'h14);
        csr_raddr_i = CSR_MTVEC;
        rst_i = 1'b1;
        #1;
        chk("midrst_redir_valid", redirect_valid_o, 0);
        chk("midrst_redir_pc", redirect_pc_o, 0);
        chk("midrst_mtvec", csr_rdata_o, 32'h100);
        chk("midrst_satp", satp_o, 0);
        tick();
        rst_i = 1'b0;
        tick();

        csr_wr(CSR_MINSTRET, 32'hFFFF_FFFF);
        tick();
        clear();
        cif.commit_valid = 1'b1;
        tick();
        tick();
        clear();
        rd("minstret_lo", CSR_MINSTRET, 32'h1);
        rd("minstret_hi", CSR_MINSTRETH, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
